// File: rtl/fdn_coef_loader.sv
// rtl/fdn_coef_loader.sv - coefficient stream loader for the diagram cores
// Optional double-buffered banking is enabled by defining FDN_COEF_DBUF_EN.
module fdn_coef_loader #(
  parameter int W_COEF    = 24,
  parameter int N_CHANALS = 32,
  parameter int N_DN      = 72,
  localparam int AW       = (N_CHANALS > 1) ? $clog2(N_CHANALS) : 1,
  localparam int DW       = (N_DN > 1) ? $clog2(N_DN) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              coef_vld,
  input  logic              coef_last,
  output logic              coef_rdy,
  input  logic [W_COEF-1:0] coef_re,
  input  logic [W_COEF-1:0] coef_im,
  input  logic              data_busy,
  input  logic              frame_sync,
  output logic [N_DN-1:0]   wr_en,
  output logic [AW-1:0]     wr_addr,
  output logic [W_COEF-1:0] wr_re,
  output logic [W_COEF-1:0] wr_im,
  output logic              bank_sel,
  output logic              bank_wr,
  output logic              load_done,
  output logic              err_short,
  output logic              err_long,
  input  logic              err_clr
);

`ifdef FDN_COEF_DBUF_EN
  typedef enum logic [1:0] {LOAD, DRAIN, WAIT_SWAP} state_t;
`else
  typedef enum logic [1:0] {LOAD, DRAIN} state_t;
`endif

  state_t          state;
  state_t          state_nxt;
  logic [AW-1:0]   ch_cnt;
  logic [AW-1:0]   ch_nxt;
  logic [DW-1:0]   dn_cnt;
  logic [DW-1:0]   dn_nxt;
  logic            rdy_arm;
  logic            accept;
  logic            last_pos;
  logic            wr_v;
  logic            done_nxt;
  logic            set_short;
  logic            set_long;
  logic            swap;

  // rdy_arm holds the ready low for the first cycle after reset release
  assign accept   = coef_vld & coef_rdy;
  assign last_pos = (ch_cnt == AW'(N_CHANALS - 1)) && (dn_cnt == DW'(N_DN - 1));

`ifdef FDN_COEF_DBUF_EN
  // the coefficient memory can be refilled while the datapath reads the other bank
  assign coef_rdy = rdy_arm & ((state == LOAD) | (state == DRAIN));
`else
  // single bank: only load while the datapath is idle; frame_sync has no role
  logic unused_sync;
  assign unused_sync = frame_sync;
  assign coef_rdy    = rdy_arm & ((state == LOAD) | (state == DRAIN)) & ~data_busy;
`endif

  // next-state, counter advance and event decode
  always_comb begin
    state_nxt = state;
    ch_nxt    = ch_cnt;
    dn_nxt    = dn_cnt;
    wr_v      = 1'b0;
    done_nxt  = 1'b0;
    set_short = 1'b0;
    set_long  = 1'b0;
    swap      = 1'b0;
    case (state)
      LOAD: begin
        if (accept) begin
          wr_v = 1'b1;
          if (coef_last) begin
            ch_nxt = '0;
            dn_nxt = '0;
            if (last_pos) begin
              done_nxt = 1'b1;
`ifdef FDN_COEF_DBUF_EN
              state_nxt = WAIT_SWAP;
`endif
            end else begin
              set_short = 1'b1;
            end
          end else if (last_pos) begin
            set_long  = 1'b1;
            ch_nxt    = '0;
            dn_nxt    = '0;
            state_nxt = DRAIN;
          end else if (ch_cnt == AW'(N_CHANALS - 1)) begin
            ch_nxt = '0;
            dn_nxt = dn_cnt + DW'(1);
          end else begin
            ch_nxt = ch_cnt + AW'(1);
          end
        end
      end
      DRAIN: begin
        // excess beats are swallowed until the stream's own end marker
        if (accept && coef_last) begin
          ch_nxt    = '0;
          dn_nxt    = '0;
          state_nxt = LOAD;
        end
      end
`ifdef FDN_COEF_DBUF_EN
      WAIT_SWAP: begin
        // swap on a frame boundary, or at once when no frame is in flight
        if (frame_sync || !data_busy) begin
          swap      = 1'b1;
          state_nxt = LOAD;
        end
      end
`endif
      default: state_nxt = LOAD;
    endcase
  end

  // control state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= LOAD;
      ch_cnt  <= '0;
      dn_cnt  <= '0;
      rdy_arm <= 1'b0;
    end else begin
      state   <= state_nxt;
      ch_cnt  <= ch_nxt;
      dn_cnt  <= dn_nxt;
      rdy_arm <= 1'b1;
    end
  end

  // one-cycle registered write port toward the core memories
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_en   <= '0;
      wr_addr <= '0;
      wr_re   <= '0;
      wr_im   <= '0;
    end else begin
      wr_en <= wr_v ? (N_DN'(1) << dn_cnt) : '0;
      if (wr_v) begin
        wr_addr <= ch_cnt;
        wr_re   <= coef_re;
        wr_im   <= coef_im;
      end
    end
  end

  // completion pulse and sticky error flags (a new error beats a clear)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      load_done <= 1'b0;
      err_short <= 1'b0;
      err_long  <= 1'b0;
    end else begin
      load_done <= done_nxt;
      err_short <= set_short | (err_short & ~err_clr);
      err_long  <= set_long  | (err_long  & ~err_clr);
    end
  end

`ifdef FDN_COEF_DBUF_EN
  // bank pointer flips only when a completed load is handed over
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bank_sel <= 1'b0;
    end else if (swap) begin
      bank_sel <= ~bank_sel;
    end
  end
  assign bank_wr = ~bank_sel;
`else
  logic unused_swap;
  assign unused_swap = swap;
  assign bank_sel    = 1'b0;
  assign bank_wr     = 1'b0;
`endif

endmodule

// File: doc/fdn_coef_loader.md
FDN_COEF_LOADER -- requirements
Module: fdn_coef_loader

Interface
REQ-001 SHALL have parameter W_COEF, default 24, coefficient Re/Im width in bits.
REQ-002 SHALL have parameter N_CHANALS, default 32, channels per diagram (>=2).
REQ-003 SHALL have parameter N_DN, default 72, number of diagram cores (>=2).
REQ-004 SHALL have port clk  in  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-006 SHALL have ports coef_vld in 1, coef_last in 1, coef_rdy out 1: coefficient stream handshake; beat accepted when coef_vld & coef_rdy.
REQ-007 SHALL have ports coef_re, coef_im  in  W_COEF  coefficient payload.
REQ-008 SHALL have port data_busy  in  1  data stream to the cores is active.
REQ-009 SHALL have port frame_sync  in  1  one-cycle pulse on the last data beat of a frame.
REQ-010 SHALL have port wr_en  out  N_DN  one-hot write strobe per diagram core.
REQ-011 SHALL have ports wr_addr out log2(N_CHANALS), wr_re/wr_im out W_COEF: write address and data.
REQ-012 SHALL have ports bank_sel out 1 (bank read by datapath), bank_wr out 1 (bank being written).
REQ-013 SHALL have ports load_done out 1 (pulse), err_short out 1, err_long out 1 (sticky), err_clr in 1.

Function
REQ-014 SHALL count accepted beats with ch_cnt (0..N_CHANALS-1, wraps to 0 and increments dn_cnt) and dn_cnt (0..N_DN-1).
REQ-015 SHALL register each accepted beat: next cycle wr_en[dn_cnt]=1 only, wr_addr=ch_cnt, wr_re/wr_im=payload; latency exactly 1 cycle; wr_en=0 otherwise.
REQ-016 SHALL implement states LOAD, DRAIN, WAIT_SWAP; reset state LOAD.
REQ-017 LOAD: accepted beat with coef_last at ch_cnt=N_CHANALS-1, dn_cnt=N_DN-1 SHALL be written, pulse load_done next cycle, clear counters, go WAIT_SWAP.
REQ-018 LOAD: coef_last at any earlier position SHALL write that beat, set err_short, clear counters, stay LOAD, no load_done, no swap.
REQ-019 LOAD: final position accepted without coef_last SHALL write it, set err_long, go DRAIN.
REQ-020 DRAIN: coef_rdy=1, no writes; accepted beat with coef_last SHALL clear counters and return to LOAD.
REQ-021 WAIT_SWAP: coef_rdy=0; frame_sync SHALL toggle bank_sel and bank_wr next cycle and return to LOAD; with data_busy=0, transition SHALL occur without frame_sync.
REQ-022 frame_sync in the same cycle the final beat is accepted SHALL NOT cause the swap; swap waits for a later frame_sync or data_busy=0.
REQ-023 err_short/err_long SHALL stay set until err_clr; set and err_clr in same cycle: set wins.
REQ-024 bank_wr SHALL always equal ~bank_sel when double-buffering is compiled in.

Reset
REQ-025 rst SHALL asynchronously force: state LOAD, counters 0, wr_en 0, wr_addr 0, wr_re/wr_im 0, bank_sel 0, bank_wr 1 (0 without macro), load_done 0, err_short 0, err_long 0, coef_rdy 0.
REQ-026 rst mid-load SHALL discard the partial load; no swap, no load_done after release.
REQ-027 coef_rdy SHALL be 0 in first cycle after rst release.

Configuration
REQ-028 Macro FDN_COEF_DBUF_EN defined: double-banked per REQ-017..REQ-024; coef_rdy in LOAD/DRAIN = 1 regardless of data_busy.
REQ-029 Macro undefined: single bank; bank_sel=bank_wr=0 constant; WAIT_SWAP absent (final beat returns to LOAD with load_done); coef_rdy = ~data_busy in LOAD/DRAIN; frame_sync ignored.

Verification (N_CHANALS=4, N_DN=3, W_COEF=8, macro defined unless noted)
REQ-030 12 beats re=0..11, last on beat 11 -> wr_en 001,001,001,001,010x4,100x4, wr_addr 0,1,2,3 repeating, load_done once, one cycle after beat 11.
REQ-031 Load completes, data_busy=1, frame_sync 5 cycles later -> coef_rdy=0 until swap; bank_sel 0->1, bank_wr 1->0 one cycle after frame_sync.
REQ-032 last on beat 6 -> err_short=1, no load_done, next 12-beat load starts at wr_en=001 addr 0; err_clr -> err_short=0.
REQ-033 14 beats, last on beat 13 -> err_long=1 after beat 11, beats 12-13 not written, back to LOAD, no swap.
REQ-034 rst pulse after beat 5 -> all outputs per REQ-025 immediately; following full load writes from addr 0, wr_en=001.
REQ-035 Macro undefined, data_busy=1 -> coef_rdy=0; data_busy=0, 12 beats -> load_done, bank_sel stays 0.
